cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, meaning number of producer channels (range 2..16).
REQ-002 SHALL have parameter DATA_W, default 32, meaning broadcast data width.
REQ-003 SHALL have parameter TAG_W, default 4, meaning reservation-station tag width; tag 0 is reserved as "no tag".
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req  input  NUM_SRC  per-channel broadcast request.
REQ-007 SHALL have port src_data  input  NUM_SRC*DATA_W  channel i data in bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port src_tag  input  NUM_SRC*TAG_W  channel i tag in bits [i*TAG_W +: TAG_W].
REQ-009 SHALL have port flush  input  1  cancels arbitration this cycle.
REQ-010 SHALL have port gnt  output  NUM_SRC  one-hot (or zero) combinational grant.
REQ-011 SHALL have port cdb_valid  output  1  registered broadcast valid.
REQ-012 SHALL have port cdb_data  output  DATA_W  registered broadcast data.
REQ-013 SHALL have port cdb_tag  output  TAG_W  registered broadcast tag.

Function
REQ-014 SHALL assert at most one gnt bit per cycle, and only for a channel whose req is 1.
REQ-015 SHALL assert some gnt bit whenever req is nonzero and flush and rst are both 0.
REQ-016 SHALL drive gnt all-zero when req is zero, flush is 1, or rst is 1.
REQ-017 SHALL count a transfer on channel i in a cycle where req[i] and gnt[i] are both 1; producer holds req, data and tag stable until granted.
REQ-018 SHALL register the granted channel's data and tag into cdb_data/cdb_tag, with cdb_valid=1, at the edge ending the grant cycle (latency 1 cycle).
REQ-019 SHALL, in cycles with no grant, load cdb_valid=0, cdb_data=0 and cdb_tag=0 at the next edge; a broadcast lasts exactly one cycle.
REQ-020 SHALL sustain one broadcast per cycle under continuous requests (no bubbles).
REQ-021 SHALL treat a requesting channel with src_tag 0 as a normal transfer (no filtering); tag legality is the producer's responsibility.
REQ-022 SHALL, when flush=1, leave the round-robin pointer unchanged.
REQ-023 SHALL, when flush=1, not suppress a broadcast already in the output register that cycle.

Reset
REQ-024 SHALL, while rst=1 at a clock edge, set cdb_valid=0, cdb_data=0, cdb_tag=0 and round-robin pointer=0.
REQ-025 SHALL give rst priority over flush and req; a grant is never issued in a reset cycle, including reset mid-stream.
REQ-026 SHALL have the first broadcast after reset deassertion appear no earlier than one cycle after the first non-reset grant.

Configuration
REQ-027 SHALL use the macro CDB_RR_EN to select the arbitration policy.
REQ-028 SHALL, with CDB_RR_EN defined, arbitrate round-robin.
REQ-029 SHALL, in round-robin mode, search from the pointer ptr upward with wrap modulo NUM_SRC, granting the first requester found.
REQ-030 SHALL, in round-robin mode, set ptr to (granted index + 1) mod NUM_SRC after each grant, and leave ptr unchanged when there is no grant.
REQ-031 SHALL, with CDB_RR_EN undefined, grant the highest-index requester (fixed priority).
REQ-032 SHALL, with CDB_RR_EN undefined, omit the pointer register entirely.

Verification
REQ-033 SHALL cover: req=4'b0100, src_tag ch2=4'h5, ch2 data=32'hDEADBEEF -> gnt=4'b0100 that cycle; next cycle cdb_valid=1, cdb_tag=5, cdb_data=DEADBEEF; following cycle cdb_valid=0.
REQ-034 SHALL cover: fixed mode, req=4'b1011 held -> gnt=4'b1000 each cycle; ch3 never starves the bench's check of exclusivity.
REQ-035 SHALL cover: RR mode, req=4'b1111 held 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3, with cdb_valid=1 on every cycle from the second.
REQ-036 SHALL cover: RR mode, ptr=2 and req=4'b0011 -> gnt=4'b0001 (wrap-around); ptr becomes 1.
REQ-037 SHALL cover: flush=1 with req=4'b0010 -> gnt=0, next cycle cdb_valid=0, ptr unchanged; flush=0 next cycle -> gnt=4'b0010.
REQ-038 SHALL cover: rst asserted in cycle after a grant with req=4'b1111 -> next edge cdb_valid=0, cdb_tag=0, ptr=0; first post-reset grant is channel 0 (RR) or channel 3 (fixed).

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: picks one producer channel per cycle and registers its data/tag for broadcast.
// Policy macro CDB_RR_EN: defined -> round-robin, undefined -> fixed priority (highest index wins).
module cdb_arbiter #(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TAG_W   = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_SRC-1:0]        req,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
   input  logic                      flush,
   output logic [NUM_SRC-1:0]        gnt,
   output logic                      cdb_valid,
   output logic [DATA_W-1:0]         cdb_data,
   output logic [TAG_W-1:0]          cdb_tag
);

   localparam int unsigned IDX_W = $clog2(NUM_SRC);

   logic               grant_en;
   logic [IDX_W-1:0]   sel_idx;
   logic [DATA_W-1:0]  data_mux;
   logic [TAG_W-1:0]   tag_mux;

   logic               cdb_valid_q, cdb_valid_d;
   logic [DATA_W-1:0]  cdb_data_q,  cdb_data_d;
   logic [TAG_W-1:0]   cdb_tag_q,   cdb_tag_d;

   // Reset and flush both veto the grant; reset wins by also clearing state below.
   assign grant_en = (|req) & ~flush & ~rst;

`ifdef CDB_RR_EN
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W:0]   cand;
   logic             found;

   // Search upward from the pointer, wrapping modulo NUM_SRC.
   always_comb begin
      sel_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(NUM_SRC)) begin
            cand = cand - (IDX_W+1)'(NUM_SRC);
         end
         if (!found && req[cand[IDX_W-1:0]]) begin
            found   = 1'b1;
            sel_idx = cand[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (grant_en) begin
         ptr_d = (sel_idx == IDX_W'(NUM_SRC-1)) ? '0 : sel_idx + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   // Later (higher) indices overwrite earlier ones, so the highest requester wins.
   always_comb begin
      sel_idx = '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         if (req[k]) begin
            sel_idx = IDX_W'(k);
         end
      end
   end
`endif

   always_comb begin
      gnt = '0;
      if (grant_en) begin
         gnt[sel_idx] = 1'b1;
      end
   end

   always_comb begin
      data_mux = '0;
      tag_mux  = '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         if (IDX_W'(k) == sel_idx) begin
            data_mux = src_data[k*DATA_W +: DATA_W];
            tag_mux  = src_tag[k*TAG_W +: TAG_W];
         end
      end
   end

   // A broadcast lives for exactly one cycle; idle cycles load zeros.
   always_comb begin
      cdb_valid_d = grant_en;
      cdb_data_d  = grant_en ? data_mux : '0;
      cdb_tag_d   = grant_en ? tag_mux  : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cdb_valid_q <= 1'b0;
         cdb_data_q  <= '0;
         cdb_tag_q   <= '0;
      end else begin
         cdb_valid_q <= cdb_valid_d;
         cdb_data_q  <= cdb_data_d;
         cdb_tag_q   <= cdb_tag_d;
      end
   end

   assign cdb_valid = cdb_valid_q;
   assign cdb_data  = cdb_data_q;
   assign cdb_tag   = cdb_tag_q;

endmodule
